scope_edge_irq_pio: RTL and testbench
=====================================

// Module: scope_edge_irq_pio
// PURPOSE
//  Parametrised Avalon-MM input PIO with a per-bit glitch filter, per-bit programmable
//  edge detection (rising/falling/both), write-1-to-clear edge capture and masked IRQ.
//  Successor to the single-bit pen-IRQ port: serves touch pen, trigger and front-panel
//  key inputs in the scope SOPC system. Sits between asynchronous board pins and the Nios IRQ line.
// PARAMETERS
//  WIDTH        8     number of input bits (1..32)
//  DEBOUNCE     4     stable cycles required before filtered value changes; 0 = bypass
//  RESET_RISE   0     reset value of rise_en register (WIDTH bits, LSB-aligned)
//  RESET_FALL   '1    reset value of fall_en register (all ones = falling edge, as pen IRQ)
// PORTS
//  clk          in   1      system clock
//  reset_n      in   1      asynchronous, active-low reset
//  address      in   3      Avalon word address
//  chipselect   in   1      Avalon select
//  write_n      in   1      Avalon write strobe, active low
//  writedata    in   32     Avalon write data
//  readdata     out  32     Avalon read data, registered
//  in_port      in   WIDTH  asynchronous input pins
//  irq          out  1      level interrupt to CPU
// BEHAVIOUR
//  Register map (unused bits read 0, writes to them ignored):
//   0 data     RO  filtered input value          1 reserved  RO 0
//   2 irq_mask RW  per-bit IRQ enable            3 edge_cap  W1C per-bit captured edge
//   4 rise_en  RW  capture rising edges          5 fall_en   RW  capture falling edges
//   6,7 reserved, read 0.
//  Reset: readdata=0, irq_mask=0, edge_cap=0, rise_en=RESET_RISE, fall_en=RESET_FALL,
//   sync flops=0, filtered=0, debounce counters=0; irq=0.
//  Input path per bit: 2-flop synchroniser -> debounce filter -> 1-cycle delayed copy.
//  Debounce: counter clears whenever sync value == filtered value; otherwise increments;
//   when counter reaches DEBOUNCE-1 while still differing, filtered <= sync on the next edge and
//   counter clears. A pulse shorter than DEBOUNCE cycles never reaches filtered. DEBOUNCE=0:
//   filtered = sync output directly (no counter). Counter width $clog2(DEBOUNCE+1).
//  Pin-to-filtered latency: 2 (sync) + DEBOUNCE cycles. Edge detected 1 cycle after filtered changes.
//  Edge detect: rise = filtered & ~prev & rise_en; fall = ~filtered & prev & fall_en.
//  edge_cap[i] sets on rise[i]|fall[i]; a write to addr 3 clears bits where writedata[i]=1.
//   Same-cycle set and clear on a bit: set wins (event never lost). Other bits unaffected.
//  Changing rise_en/fall_en takes effect on the next cycle; already-captured bits are kept.
//  irq = |(edge_cap & irq_mask), combinational from registers (no extra latency, no glitch source).
//   Writing irq_mask never alters edge_cap; unmasking a set bit asserts irq the next cycle.
//  readdata registered every clock from address (read latency 1, chipselect not required), as the
//   existing PIOs; no read side effects.
//  Writes: chipselect & ~write_n; writedata[WIDTH-1:0] used.
//  reset_n assertion mid-debounce or mid-capture clears all state immediately; first edge after
//   reset release needs filtered to go 0->1 (rise) so a pin held high at reset yields one rise event
//   only if rise_en=1.
// STRUCTURE
//  Package scope_pio_pkg: address constants ADDR_DATA..ADDR_FALL_EN (3-bit), data width 32.
//  Sub-module scope_pio_debounce (1 bit, params DEBOUNCE): sync pair + counter + filtered flop;
//   instantiated WIDTH times in a generate loop. Top holds registers, edge logic, read mux.
// TESTING
//  1 Reset, read addrs 0..7 -> data 0, mask 0, cap 0, rise 0x00, fall 0xFF, reserved 0; irq=0.
//  2 DEBOUNCE=4, pulse in_port[0] high 3 cycles -> data stays 0, cap 0; hold 8 cycles ->
//    data[0]=1 exactly 2+4 cycles after pin edge.
//  3 fall_en=0x01, mask=0x01: drive bit0 1 then 0 -> cap=0x01 and irq=1; write 0x01 to addr 3 ->
//    cap=0, irq=0 next cycle.
//  4 rise_en=fall_en=0x0F: toggle bits 0..3 -> cap=0x0F; write 0x05 to cap -> cap=0x0A.
//  5 Edge on bit2 lands the same cycle as W1C 0x04 -> cap[2] remains 1.
//  6 mask=0, capture bit1, then write mask=0x02 -> irq rises next cycle; assert reset_n low
//    mid-debounce -> all registers and irq return to reset values asynchronously.

Source files
------------

// File: rtl/scope_pio_pkg.sv
// Shared constants for the scope edge-capture input PIO.
// Avalon word addresses and bus width.
package scope_pio_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_RSVD     = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd5;

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/scope_pio_debounce.sv
// One-bit input conditioner: 2-flop synchroniser plus
// a stable-count glitch filter (bypassed when DEBOUNCE=0).
module scope_pio_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic filtered
);

  logic [1:0] sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= '0;
    else          sync <= {sync[0], pin};
  end

  if (DEBOUNCE == 0) begin : g_bypass
    assign filtered = sync[1];
  end else begin : g_filter
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic [CW-1:0] cnt;
    logic          filt_q;

    // Counter tracks consecutive cycles the synced value disagrees.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt    <= '0;
        filt_q <= 1'b0;
      end else if (sync[1] == filt_q) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        filt_q <= sync[1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end

    assign filtered = filt_q;
  end

endmodule

// File: rtl/scope_edge_irq_pio.sv
// Avalon-MM input PIO: filtered pins, per-bit rise/fall
// edge capture (write-1-to-clear) and masked level IRQ.
module scope_edge_irq_pio
  import scope_pio_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               DEBOUNCE   = 4,
  parameter logic [WIDTH-1:0] RESET_RISE = '0,
  parameter logic [WIDTH-1:0] RESET_FALL = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] wdat;
  logic             wr;
  word_t            rd_next;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    scope_pio_debounce #(
      .DEBOUNCE(DEBOUNCE)
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .pin     (in_port[i]),
      .filtered(filt[i])
    );
  end

  assign wr   = chipselect & ~write_n;
  assign wdat = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  assign hit = (filt & ~prev & rise_en)
             | (~filt & prev & fall_en);
  assign clr = (wr && address == ADDR_EDGE_CAP) ? wdat : '0;

  // New edges OR in after the clear so a same-cycle event survives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev    <= '0;
      cap     <= '0;
      mask    <= '0;
      rise_en <= RESET_RISE;
      fall_en <= RESET_FALL;
    end else begin
      prev <= filt;
      cap  <= (cap & ~clr) | hit;
      if (wr && address == ADDR_IRQ_MASK) mask    <= wdat;
      if (wr && address == ADDR_RISE_EN)  rise_en <= wdat;
      if (wr && address == ADDR_FALL_EN)  fall_en <= wdat;
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:     rd_next = DATA_W'(filt);
      ADDR_IRQ_MASK: rd_next = DATA_W'(mask);
      ADDR_EDGE_CAP: rd_next = DATA_W'(cap);
      ADDR_RISE_EN:  rd_next = DATA_W'(rise_en);
      ADDR_FALL_EN:  rd_next = DATA_W'(fall_en);
      default:       rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

  assign irq = |(cap & mask);

endmodule

// File: tb/tb_scope_edge_irq_pio.sv
// Self-checking bench for scope_edge_irq_pio: directed
// scenarios plus random traffic against a window-based model.
module tb_scope_edge_irq_pio;

  localparam int W  = 8;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port;
  logic          irq;

  int checks   = 0;
  int failures = 0;

  scope_edge_irq_pio #(
    .WIDTH(W),
    .DEBOUNCE(DB)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Reference model: a bit's filtered value flips once the pin,
  // seen two cycles late, has disagreed for DB samples in a row.
  logic [W-1:0] m_f    = '0;
  logic [W-1:0] m_p    = '0;
  logic [W-1:0] m_mask = '0;
  logic [W-1:0] m_cap  = '0;
  logic [W-1:0] m_rise = '0;
  logic [W-1:0] m_fall = '1;
  logic [31:0]  m_rd   = '0;
  logic [W-1:0] m_nf;
  logic [W-1:0] m_ev;
  logic [W-1:0] m_clr;
  logic         m_wr;
  logic         m_diff;
  logic [W-1:0] ph[$];
  logic         m_irq;

  assign m_irq = |(m_cap & m_mask);

  initial begin
    for (int k = 0; k < DB + 1; k++) ph.push_back('0);
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_f = '0; m_p = '0; m_mask = '0; m_cap = '0;
        m_rise = '0; m_fall = '1; m_rd = '0;
        ph.delete();
        for (int k = 0; k < DB + 1; k++) ph.push_back('0);
      end else begin
        case (address)
          3'd0:    m_rd = 32'(m_f);
          3'd2:    m_rd = 32'(m_mask);
          3'd3:    m_rd = 32'(m_cap);
          3'd4:    m_rd = 32'(m_rise);
          3'd5:    m_rd = 32'(m_fall);
          default: m_rd = '0;
        endcase
        m_nf = m_f;
        for (int i = 0; i < W; i++) begin
          m_diff = 1'b1;
          for (int j = 0; j < DB; j++)
            if (ph[j][i] == m_f[i]) m_diff = 1'b0;
          if (m_diff) m_nf[i] = ~m_f[i];
        end
        m_ev  = (m_f & ~m_p & m_rise) | (~m_f & m_p & m_fall);
        m_wr  = chipselect && !write_n;
        m_clr = (m_wr && address == 3'd3) ? writedata[W-1:0] : '0;
        m_cap = (m_cap & ~m_clr) | m_ev;
        if (m_wr && address == 3'd2) m_mask = writedata[W-1:0];
        if (m_wr && address == 3'd4) m_rise = writedata[W-1:0];
        if (m_wr && address == 3'd5) m_fall = writedata[W-1:0];
        m_p = m_f;
        m_f = m_nf;
        ph.push_back(in_port);
        void'(ph.pop_front());
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d;
    chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = '0; writedata = '0; in_port = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq got=%b exp=0", irq);
    end
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d);
      e = (a == 5) ? 32'h0000_00FF : 32'h0;
      checks++;
      if (d !== e) begin
        failures++;
        $display("FAIL reset_reg%0d got=%h exp=%h", a, d, e);
      end
    end
  endtask

  task automatic test_debounce();
    logic seen;
    int   n;
    logic [31:0] d;
    address = 3'd0;
    in_port[0] = 1'b1;
    repeat (3) tick();
    in_port[0] = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (readdata[0]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL short_pulse got=%b exp=0", seen);
    end
    rd(3'd3, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL short_pulse_cap got=%h exp=0", d);
    end
    // 2 sync + 4 filter cycles to filtered, +1 read latency
    address = 3'd0;
    in_port[0] = 1'b1;
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (readdata[0] === 1'b1) break;
    end
    checks++;
    if (n != 7) begin
      failures++;
      $display("FAIL debounce_latency got=%0d exp=7", n);
    end
  endtask

  task automatic test_fall_irq();
    logic [31:0] d;
    wr(3'd4, 32'h00);
    wr(3'd5, 32'h01);
    wr(3'd2, 32'h01);
    wr(3'd3, 32'hFF);
    repeat (10) tick();
    in_port[0] = 1'b0;
    repeat (10) tick();
    rd(3'd3, d);
    checks++;
    if (d !== 32'h01) begin
      failures++;
      $display("FAIL fall_cap got=%h exp=01", d);
    end
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL fall_irq got=%b exp=1", irq);
    end
    wr(3'd3, 32'h01);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL w1c_irq got=%b exp=0", irq);
    end
    rd(3'd3, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL w1c_cap got=%h exp=0", d);
    end
  endtask

  task automatic test_both_edges();
    logic [31:0] d;
    wr(3'd4, 32'h0F);
    wr(3'd5, 32'h0F);
    wr(3'd3, 32'hFF);
    in_port[3:0] = ~in_port[3:0];
    repeat (10) tick();
    rd(3'd3, d);
    checks++;
    if (d !== 32'h0F) begin
      failures++;
      $display("FAIL toggle_cap got=%h exp=0f", d);
    end
    wr(3'd3, 32'h05);
    rd(3'd3, d);
    checks++;
    if (d !== 32'h0A) begin
      failures++;
      $display("FAIL partial_w1c got=%h exp=0a", d);
    end
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    in_port[2] = ~in_port[2];
    repeat (10) tick();
    rd(3'd3, d);
    checks++;
    if (d !== 32'h0E) begin
      failures++;
      $display("FAIL bit2_cap got=%h exp=0e", d);
    end
    // the new edge is captured on the 7th edge after the pin moves
    in_port[2] = ~in_port[2];
    repeat (6) tick();
    wr(3'd3, 32'h04);
    rd(3'd3, d);
    checks++;
    if (d !== 32'h0E) begin
      failures++;
      $display("FAIL set_wins got=%h exp=0e", d);
    end
    wr(3'd3, 32'h04);
    rd(3'd3, d);
    checks++;
    if (d !== 32'h0A) begin
      failures++;
      $display("FAIL plain_clear got=%h exp=0a", d);
    end
  endtask

  task automatic test_mask_and_reset();
    logic [31:0] d;
    wr(3'd2, 32'h00);
    wr(3'd3, 32'hFF);
    in_port[1] = ~in_port[1];
    repeat (10) tick();
    rd(3'd3, d);
    checks++;
    if (d !== 32'h02 || irq !== 1'b0) begin
      failures++;
      $display("FAIL masked_cap got=%h/%b exp=02/0", d, irq);
    end
    wr(3'd2, 32'h02);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL unmask_irq got=%b exp=1", irq);
    end
    address = 3'd2;
    in_port[5] = ~in_port[5];
    repeat (3) tick();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (irq !== 1'b0 || readdata !== 32'h0) begin
      failures++;
      $display("FAIL async_reset got=%b/%h exp=0/0", irq, readdata);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    rd(3'd2, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL reset_mask got=%h exp=0", d);
    end
    rd(3'd3, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL reset_cap got=%h exp=0", d);
    end
    rd(3'd4, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL reset_rise got=%h exp=0", d);
    end
    rd(3'd5, d);
    checks++;
    if (d !== 32'hFF) begin
      failures++;
      $display("FAIL reset_fall got=%h exp=ff", d);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 15) == 0) in_port[b] = ~in_port[b];
      address    = 3'($urandom_range(0, 7));
      writedata  = $urandom;
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if (readdata !== m_rd) begin
        failures++;
        $display("FAIL rand_rd cyc=%0d got=%h exp=%h", c, readdata, m_rd);
      end
      checks++;
      if (irq !== m_irq) begin
        failures++;
        $display("FAIL rand_irq cyc=%0d got=%b exp=%b", c, irq, m_irq);
      end
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_fall_irq();
    test_both_edges();
    test_set_wins();
    test_mask_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
